// File: rtl/multicycle_alu_pkg.sv
// Shared definitions for the parametrised multicycle ALU: operation codes and FSM states.
package multicycle_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXEC   = 2'd1;
    localparam logic [1:0] ITER   = 2'd2;
    localparam logic [1:0] FINISH = 2'd3;

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative datapath shared by shift-add multiply and restoring divide.
// hi/lo form one double-width register: {upper product, multiplier} or {remainder, quotient}.
module seq_muldiv_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] next_hi,
    output logic [WIDTH-1:0] next_lo,
    output logic             last
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    count;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;

    // next_* is the value after one step, so the owner can capture the final result on the last edge
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, d} : '0);
        rem_shift = {hi, lo[WIDTH-1]};
        trial     = rem_shift - {1'b0, d};
        if (is_div) begin
            next_hi = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
            next_lo = {lo[WIDTH-2:0], ~trial[WIDTH]};
        end else begin
            next_hi = mul_sum[WIDTH:1];
            next_lo = {mul_sum[0], lo[WIDTH-1:1]};
        end
    end

    assign last = (count == CW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            hi    <= '0;
            lo    <= '0;
            d     <= '0;
            count <= '0;
        end else if (load) begin
            hi    <= '0;
            lo    <= is_div ? a : b;
            d     <= is_div ? b : a;
            count <= CW'(WIDTH);
        end else if (step) begin
            hi    <= next_hi;
            lo    <= next_lo;
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/multicycle_alu_gen.sv
// WIDTH-bit multicycle ALU: single-cycle add/sub, iterative mul/div behind a start/done handshake.
module multicycle_alu_gen
    import multicycle_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] result,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero
);

    logic [1:0]       state;
    op_e              op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             core_load;
    logic             core_step;
    logic             core_last;
    logic [WIDTH-1:0] core_hi;
    logic [WIDTH-1:0] core_lo;

    assign core_step = (state == ITER);
    assign core_load = (state == EXEC) &&
                       ((op_q == OP_MUL) || ((op_q == OP_DIV) && (b_q != '0)));

    seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .rst     (rst),
        .load    (core_load),
        .step    (core_step),
        .is_div  (op_q == OP_DIV),
        .a       (a_q),
        .b       (b_q),
        .next_hi (core_hi),
        .next_lo (core_lo),
        .last    (core_last)
    );

    // done and busy are registered alongside the state so they line up with FINISH/EXEC/ITER
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= OP_ADD;
            a_q         <= '0;
            b_q         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q        <= op_e'(op);
                        a_q         <= a;
                        b_q         <= b;
                        busy        <= 1'b1;
                        div_by_zero <= 1'b0;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    if (op_q == OP_ADD || op_q == OP_SUB) begin
                        result    <= (op_q == OP_ADD) ? ({{WIDTH{1'b0}}, a_q} + {{WIDTH{1'b0}}, b_q})
                                                      : ({{WIDTH{1'b0}}, a_q} - {{WIDTH{1'b0}}, b_q});
                        remainder <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= FINISH;
                    end else if (op_q == OP_DIV && b_q == '0) begin
                        result      <= {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                        remainder   <= a_q;
                        div_by_zero <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        state       <= FINISH;
                    end else begin
                        state <= ITER;
                    end
                end
                ITER: begin
                    if (core_last) begin
                        if (op_q == OP_DIV) begin
                            result    <= {{WIDTH{1'b0}}, core_lo};
                            remainder <= core_hi;
                        end else begin
                            result    <= {core_hi, core_lo};
                            remainder <= '0;
                        end
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FINISH;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu_gen.sv
// Self-checking bench: vector table, hand-written handshake corner cases and a randomized run against a plain-arithmetic model.
module tb_multicycle_alu_gen;
    import multicycle_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [7:0]  a, b;
    logic        busy, done, div_by_zero;
    logic [15:0] result;
    logic [7:0]  remainder;

    logic        start16;
    logic [1:0]  op16;
    logic [15:0] a16, b16;
    logic        busy16, done16, dbz16;
    logic [31:0] result16;
    logic [15:0] rem16;

    int testsRun;
    int testsFailed;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] result;
        logic [7:0]  rem;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t tbl[9];

    always #5 clk = ~clk;

    multicycle_alu_gen #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    multicycle_alu_gen #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .op(op16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .result(result16), .remainder(rem16),
        .div_by_zero(dbz16)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference behaviour for WIDTH=8 from plain integer arithmetic
    task automatic refModel(input logic [1:0] o, input int unsigned av, input int unsigned bv,
                            output int unsigned res, output int unsigned rem, output bit dbz, output int lat);
        rem = 0;
        dbz = 1'b0;
        lat = 2;
        case (o)
            2'd0: res = av + bv;
            2'd1: res = (av - bv) & 32'hFFFF;
            2'd2: begin res = av * bv; lat = 10; end
            default: begin
                if (bv == 0) begin
                    res = 32'hFF;
                    rem = av;
                    dbz = 1'b1;
                end else begin
                    res = av / bv;
                    rem = av % bv;
                    lat = 10;
                end
            end
        endcase
    endtask

    task automatic applyStimulus(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                                 output logic [15:0] r, output logic [7:0] rm, output logic z,
                                 output int edges, output int busyCycles);
        @(negedge clk);
        if (done) @(negedge clk);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        edges = 0;
        busyCycles = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
            start = 1'b0;
            op = 2'($urandom);
            a = 8'($urandom);
            b = 8'($urandom);
            if (busy) busyCycles++;
        end while (!done && edges < 100);
        r = result;
        rm = remainder;
        z = div_by_zero;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] r;
        logic [7:0]  rm;
        logic        z;
        int          edges, busyCycles, doneCount, doneEdge;
        int unsigned expRes, expRem;
        bit          expDbz;
        int          expLat;
        logic [1:0]  ro;
        logic [7:0]  ra, rb;

        testsRun = 0;
        testsFailed = 0;
        rst = 1'b1;
        start = 1'b0; op = '0; a = '0; b = '0;
        start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;

        tbl[0] = '{OP_ADD, 8'd15,  8'd10,  16'd25,    8'd0,  1'b0, 2};
        tbl[1] = '{OP_SUB, 8'd20,  8'd5,   16'd15,    8'd0,  1'b0, 2};
        tbl[2] = '{OP_SUB, 8'd5,   8'd20,  16'hFFF1,  8'd0,  1'b0, 2};
        tbl[3] = '{OP_MUL, 8'd4,   8'd3,   16'd12,    8'd0,  1'b0, 10};
        tbl[4] = '{OP_MUL, 8'd255, 8'd255, 16'd65025, 8'd0,  1'b0, 10};
        tbl[5] = '{OP_DIV, 8'd40,  8'd8,   16'd5,     8'd0,  1'b0, 10};
        tbl[6] = '{OP_DIV, 8'd47,  8'd8,   16'd5,     8'd7,  1'b0, 10};
        tbl[7] = '{OP_DIV, 8'd40,  8'd0,   16'h00FF,  8'd40, 1'b1, 2};
        tbl[8] = '{OP_ADD, 8'd1,   8'd2,   16'd3,     8'd0,  1'b0, 2};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset result", 32'(result), 32'h0);
        checkOutput("reset remainder", 32'(remainder), 32'h0);
        checkOutput("reset busy", 32'(busy), 32'h0);
        checkOutput("reset done", 32'(done), 32'h0);
        checkOutput("reset div_by_zero", 32'(div_by_zero), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            applyStimulus(tbl[i].op, tbl[i].a, tbl[i].b, r, rm, z, edges, busyCycles);
            checkOutput($sformatf("vec%0d result", i), 32'(r), 32'(tbl[i].result));
            checkOutput($sformatf("vec%0d remainder", i), 32'(rm), 32'(tbl[i].rem));
            checkOutput($sformatf("vec%0d div_by_zero", i), 32'(z), 32'(tbl[i].dbz));
            checkOutput($sformatf("vec%0d latency", i), 32'(edges), 32'(tbl[i].lat));
            checkOutput($sformatf("vec%0d busy cycles", i), 32'(busyCycles), 32'(tbl[i].lat - 1));
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d done width", i), 32'(done), 32'h0);
        end

        // start held high through a mul, with a div request appearing mid-operation
        @(negedge clk);
        start = 1'b1; op = OP_MUL; a = 8'd4; b = 8'd3;
        doneCount = 0;
        doneEdge = 0;
        r = '0;
        for (int e = 1; e <= 15; e++) begin
            @(posedge clk);
            #1;
            if (e == 3) begin
                op = OP_DIV; a = 8'd9; b = 8'd3;
            end
            if (done) begin
                doneCount++;
                if (doneEdge == 0) begin
                    doneEdge = e;
                    r = result;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checkOutput("held start done count", 32'(doneCount), 32'd1);
        checkOutput("held start latency", 32'(doneEdge), 32'd10);
        checkOutput("held start result", 32'(r), 32'd12);

        // reset during the 4th ITER cycle of a mul
        @(negedge clk);
        start = 1'b1; op = OP_MUL; a = 8'd7; b = 8'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("mid-op busy", 32'(busy), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort result", 32'(result), 32'h0);
        checkOutput("abort remainder", 32'(remainder), 32'h0);
        checkOutput("abort busy", 32'(busy), 32'h0);
        checkOutput("abort done", 32'(done), 32'h0);
        rst = 1'b0;
        doneCount = 0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk);
            #1;
            if (done) doneCount++;
        end
        checkOutput("abort no done", 32'(doneCount), 32'd0);
        applyStimulus(OP_ADD, 8'd1, 8'd1, r, rm, z, edges, busyCycles);
        checkOutput("post-abort add result", 32'(r), 32'd2);
        checkOutput("post-abort add latency", 32'(edges), 32'd2);

        // randomized operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom);
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            refModel(ro, 32'(ra), 32'(rb), expRes, expRem, expDbz, expLat);
            applyStimulus(ro, ra, rb, r, rm, z, edges, busyCycles);
            checkOutput($sformatf("rand%0d op%0d %0d,%0d result", i, ro, ra, rb), 32'(r), expRes);
            checkOutput($sformatf("rand%0d remainder", i), 32'(rm), expRem);
            checkOutput($sformatf("rand%0d div_by_zero", i), 32'(z), 32'(expDbz));
            checkOutput($sformatf("rand%0d latency", i), 32'(edges), 32'(expLat));
        end

        // WIDTH=16 instance: full-scale multiply
        @(negedge clk);
        start16 = 1'b1; op16 = OP_MUL; a16 = 16'hFFFF; b16 = 16'hFFFF;
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
            start16 = 1'b0;
            a16 = 16'($urandom);
        end while (!done16 && edges < 100);
        checkOutput("w16 mul result", result16, 32'hFFFE0001);
        checkOutput("w16 mul remainder", 32'(rem16), 32'h0);
        checkOutput("w16 mul latency", 32'(edges), 32'd18);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/multicycle_alu_gen.md
Name: multicycle_alu_gen

Overview:
Parametrised successor to the fixed 8-bit multicycle arithmetic unit: add, sub, mul and div on WIDTH-bit unsigned operands.
- Multiply is iterative shift-add; divide is iterative restoring division.
- Adds busy, remainder and divide-by-zero outputs.
- Sits as a shared execution unit behind a simple start/done handshake driven by a controller or testbench.

Parameters:
- WIDTH, 8, operand width in bits (legal 4..32); result is 2*WIDTH bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  request; sampled only when busy=0
- op  in  2  00 add, 01 sub, 10 mul, 11 div
- a  in  WIDTH  operand A (dividend for div)
- b  in  WIDTH  operand B (divisor for div)
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; result, remainder and div_by_zero valid
- result  out  2*WIDTH  sum, difference, product or zero-extended quotient
- remainder  out  WIDTH  div remainder; 0 for other ops
- div_by_zero  out  1  set with done when op=div and b=0

Behaviour:
- Reset: all outputs are 0 on the edge where rst=1; state goes to IDLE; internal registers cleared.
- Reset mid-operation aborts the operation with no done pulse. Reset has priority over all other inputs.
- States: IDLE, EXEC, ITER, FINISH.
- IDLE:
  - start=1 latches op, a and b; go to EXEC.
  - start=0 stays in IDLE.
- EXEC:
  - add/sub: compute result and go to FINISH.
  - mul/div with b≠0: initialise accumulator and counter = WIDTH; go to ITER.
  - div with b=0: result = all ones, remainder = a, div_by_zero=1; go to FINISH.
- ITER runs exactly WIDTH cycles; the counter decrements each cycle. At counter=1, go to FINISH.
  - mul: if multiplier LSB=1, add multiplicand into upper half of product; shift right.
  - div: shift {rem, quotient} left by 1; trial-subtract b; keep the difference and set quotient bit if no borrow.
- FINISH: done=1 for one cycle, busy=0, then IDLE. A start in the FINISH cycle is ignored.
- Latency, counted in edges from the start-sampling edge to the edge that raises done:
  - add/sub: 2
  - mul/div: WIDTH+2
  - div by zero: 2
- busy is high in EXEC and ITER, low in IDLE and FINISH.
- start while busy=1 is ignored. Inputs a, b and op may change freely after acceptance.
- Arithmetic is modulo 2^(2*WIDTH):
  - add: a+b zero-extended; carry appears in bit WIDTH.
  - sub: zero-extend both operands, then subtract; a<b wraps, e.g. 5-20 = 0xFFF1 for WIDTH=8.
  - mul: full unsigned product, no overflow possible.
  - div: quotient is in the low WIDTH bits, upper bits 0.
- Output registers hold their last values until the next operation reaches FINISH.
- div_by_zero is cleared at the next start acceptance.

Decomposition:
- Package multicycle_alu_pkg holds:
  - op encodings OP_ADD, OP_SUB, OP_MUL, OP_DIV;
  - the state enum IDLE/EXEC/ITER/FINISH.
- One sub-module, seq_muldiv_core, holds the shared iterative datapath: accumulator, shift register, counter and mul/div step logic, parametrised by WIDTH.
- multicycle_alu_gen owns the FSM, the add/sub path, the handshake and the output registers.

Test Plan:
All scenarios use WIDTH=8 unless noted.
- add 15+10 → done 2 edges after start, result=25, remainder=0. Then sub 20-5 → result=15. Then sub 5-20 → result=0xFFF1.
- mul 4*3 → result=12 with done exactly 10 edges after start and busy high 9 cycles. Also mul 255*255 → 65025.
- div 40/8 → result=5, remainder=0. Also div 47/8 → result=5, remainder=7, 10-edge latency.
- div 40/0 → done after 2 edges, div_by_zero=1, result=0x00FF, remainder=40. The next add clears div_by_zero.
- Start held high during a mul, with a second request div 9/3 issued mid-operation → ignored; only one done, result=12.
- rst asserted on the 4th ITER cycle of a mul → next edge all outputs 0, no done. A subsequent add 1+1 → 2.
- WIDTH=16: mul 0xFFFF*0xFFFF → 0xFFFE0001 in 18 edges.
